// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU_Control encodings and the mul/div sequencer states.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // True for the ALU_Control codes handled by the multi-cycle unit.
  function automatic logic is_muldiv(input logic [3:0] ctl);
    return (ctl == ALU_MUL) || (ctl == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> mul/div sequencer handshake and result bus.
interface muldiv_sequencer_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [3:0]   alu_control;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, alu_control, op_a, op_b,
    input  stall, busy, done, result, remainder, div_by_zero
  );

  modport slave (
    input  start, alu_control, op_a, op_b,
    output stall, busy, done, result, remainder, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring unsigned divide.
// MUL: sh_a = multiplicand, sh_b = multiplier, acc = product.
// DIV: sh_a = dividend, sh_b = divisor (static), acc = quotient, rem = partial remainder.
module muldiv_step #(
  parameter int unsigned N = 32
) (
  input  logic         is_div,
  input  logic [N-1:0] acc,
  input  logic [N:0]   rem,
  input  logic [N-1:0] sh_a,
  input  logic [N-1:0] sh_b,
  output logic [N-1:0] acc_next,
  output logic [N:0]   rem_next,
  output logic [N-1:0] sh_a_next,
  output logic [N-1:0] sh_b_next
);

  logic [N:0] rem_shift;
  logic [N:0] trial;

  // Next-iteration datapath values for the selected operation.
  always_comb begin
    acc_next  = acc;
    rem_next  = rem;
    sh_a_next = sh_a << 1;
    sh_b_next = sh_b;
    rem_shift = '0;
    trial     = '0;
    if (is_div) begin
      rem_shift = {rem[N-1:0], sh_a[N-1]};
      trial     = rem_shift - {1'b0, sh_b};
      if (rem_shift >= {1'b0, sh_b}) begin
        rem_next = trial;
        acc_next = {acc[N-2:0], 1'b1};
      end else begin
        rem_next = rem_shift;
        acc_next = {acc[N-2:0], 1'b0};
      end
    end else begin
      if (sh_b[0]) begin
        acc_next = acc + sh_a;
      end
      sh_b_next = sh_b >> 1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV controller: stalls the pipeline for N iterations,
// then presents result/remainder for one cycle with done.
module muldiv_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);
  import cpu_pkg::*;

  localparam int unsigned CW = $clog2(N) + 1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          op_div;
  logic [N-1:0]  acc;
  logic [N:0]    rem;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  logic [N-1:0]  acc_next;
  logic [N:0]    rem_next;
  logic [N-1:0]  sh_a_next;
  logic [N-1:0]  sh_b_next;
  logic [N-1:0]  result_q;
  logic [N-1:0]  remainder_q;
  logic          dbz_q;

  logic accept;
  logic accept_div;
  logic div_zero;
  logic running;
  logic last;

  assign accept     = (state == IDLE) && bus.start && is_muldiv(bus.alu_control);
  assign accept_div = bus.alu_control == ALU_DIV;
  assign div_zero   = accept && accept_div && (bus.op_b == '0);
  assign running    = (state == MUL) || (state == DIV);
  assign last       = count == CW'(1);

  muldiv_step #(.N(N)) u_step (
    .is_div    (op_div),
    .acc       (acc),
    .rem       (rem),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .acc_next  (acc_next),
    .rem_next  (rem_next),
    .sh_a_next (sh_a_next),
    .sh_b_next (sh_b_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; divide by zero skips the iteration states.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (div_zero) begin
            state_next = DONE;
          end else if (accept_div) begin
            state_next = DIV;
          end else begin
            state_next = MUL;
          end
        end
      end
      MUL:  if (last) state_next = DONE;
      DIV:  if (last) state_next = DONE;
      DONE: state_next = IDLE;
    endcase
  end

  // Operand latch on accept, one iteration per busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      op_div <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
    end else if (accept) begin
      count  <= CW'(N);
      op_div <= accept_div;
      acc    <= '0;
      rem    <= '0;
      sh_a   <= bus.op_a;
      sh_b   <= bus.op_b;
    end else if (running) begin
      count  <= count - CW'(1);
      acc    <= acc_next;
      rem    <= rem_next;
      sh_a   <= sh_a_next;
      sh_b   <= sh_b_next;
    end
  end

  // Result registers load only on the transition into DONE and hold otherwise.
  // The final iteration's step outputs are captured directly, so no extra cycle is spent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (div_zero) begin
      result_q    <= '1;
      remainder_q <= bus.op_a;
      dbz_q       <= 1'b1;
    end else if (running && last) begin
      result_q    <= acc_next;
      remainder_q <= op_div ? rem_next[N-1:0] : '0;
      dbz_q       <= 1'b0;
    end
  end

  assign bus.busy        = running;
  assign bus.done        = state == DONE;
  assign bus.stall       = accept | running;
  assign bus.result      = result_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
